serial_adder_ctrl: RTL and testbench

Bit-serial WIDTH-bit adder/subtractor that time-shares one full-adder cell, built from two `halfadder` instances plus an OR gate, across WIDTH clock cycles. The block latches its operands on a `start` pulse and steps an LSB-first shift/carry sequence through the shared cell. It then reports sum, carry-out and signed overflow with a one-cycle `done` pulse. It sits between a requesting controller and the arithmetic datapath, trading latency for area.

---
 rtl/serial_adder_ctrl.sv | 104 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder/subtractor: one shared full-adder cell (two half
// adders plus an OR) steps through the operands LSB first, one bit per clock.

module halfadder (
    input  logic a,
    input  logic b,
    output logic s_c,
    output logic co_c
);
    assign s_c  = a ^ b;
    assign co_c = a & b;
endmodule

module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             SUB,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V
);
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] opa, opb;
    logic [WIDTH-2:0] res;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic s1, c1, sum, c2, next_carry;
    logic last, accept;

    halfadder u_ha0 (.a(opa[0]), .b(opb[0]), .s_c(s1),  .co_c(c1));
    halfadder u_ha1 (.a(s1),     .b(carry),  .s_c(sum), .co_c(c2));

    assign next_carry = c1 | c2;
    assign last       = (state_q == RUN) && (cnt == CW'(WIDTH - 1));
    assign accept     = start && (state_q != RUN);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; start is only honoured outside RUN
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered outputs; results land only on the final bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            S     <= '0;
            Cout  <= 1'b0;
            V     <= 1'b0;
            opa   <= '0;
            opb   <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            busy <= (state_d == RUN);
            done <= (state_d == DONE);
            if (accept) begin
                opa   <= A;
                opb   <= SUB ? ~B : B;
                carry <= SUB ? 1'b1 : Cin;
                cnt   <= '0;
            end else if (state_q == RUN) begin
                opa   <= opa >> 1;
                opb   <= opb >> 1;
                res   <= (WIDTH-1)'({sum, res} >> 1);
                carry <= next_carry;
                if (last) begin
                    S    <= {sum, res};
                    Cout <= next_carry;
                    V    <= carry ^ next_carry;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: WIDTH=8 and WIDTH=2 instances checked every
// cycle against an arithmetic reference, plus directed literal cases.

module tb_serial_adder_ctrl;
    logic clk;
    logic rst_n;

    logic        st_i [2];
    logic        sub_i[2];
    logic        cin_i[2];
    logic [31:0] a_i  [2];
    logic [31:0] b_i  [2];

    logic       busy8, done8, co8, v8;
    logic [7:0] s8;
    logic       busy2, done2, co2, v2;
    logic [1:0] s2;

    logic        busy_o[2], done_o[2], co_o[2], v_o[2];
    logic [31:0] s_o[2];

    assign busy_o[0] = busy8; assign done_o[0] = done8; assign co_o[0] = co8;
    assign v_o[0] = v8; assign s_o[0] = 32'(s8);
    assign busy_o[1] = busy2; assign done_o[1] = done2; assign co_o[1] = co2;
    assign v_o[1] = v2; assign s_o[1] = 32'(s2);

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(st_i[0]), .SUB(sub_i[0]),
        .A(a_i[0][7:0]), .B(b_i[0][7:0]), .Cin(cin_i[0]),
        .busy(busy8), .done(done8), .S(s8), .Cout(co8), .V(v8)
    );

    serial_adder_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(st_i[1]), .SUB(sub_i[1]),
        .A(a_i[1][1:0]), .B(b_i[1][1:0]), .Cin(cin_i[1]),
        .busy(busy2), .done(done2), .S(s2), .Cout(co2), .V(v2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic int unsigned wid(input int i);
        return (i == 0) ? 8 : 2;
    endfunction

    function automatic logic [31:0] wmask(input int i);
        return (i == 0) ? 32'hFF : 32'h3;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic: unsigned result/carry and signed range check
    function automatic void ref_op(input int unsigned w, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub,
                                   output logic [31:0] s, output logic co, output logic v);
        longint mask = (longint'(1) << w) - 1;
        longint ua = longint'(a) & mask;
        longint ub = longint'(b) & mask;
        longint half = longint'(1) << (w - 1);
        longint sa = (ua >= half) ? ua - (mask + 1) : ua;
        longint sb = (ub >= half) ? ub - (mask + 1) : ub;
        longint r, sr;
        if (sub) begin
            r  = ua - ub;
            co = (ua >= ub);
            sr = sa - sb;
        end else begin
            r  = ua + ub + longint'(cin);
            co = (r > mask);
            sr = sa + sb + longint'(cin);
        end
        s = 32'(r & mask);
        v = (sr < -half) || (sr > half - 1);
    endfunction

    int unsigned remain[2];
    int          acc_cnt[2];
    logic        m_busy[2], m_done[2], m_co[2], m_v[2], p_co[2], p_v[2];
    logic [31:0] m_s[2], p_s[2];

    // Model: one operation in flight at a time, result appears WIDTH edges after acceptance
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                remain[i] = 0; m_busy[i] = 0; m_done[i] = 0;
                m_s[i] = 0; m_co[i] = 0; m_v[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (remain[i] > 0) begin
                    remain[i]--;
                    if (remain[i] == 0) begin
                        m_busy[i] = 0; m_done[i] = 1;
                        m_s[i] = p_s[i]; m_co[i] = p_co[i]; m_v[i] = p_v[i];
                    end
                end else if (st_i[i]) begin
                    ref_op(wid(i), a_i[i], b_i[i], cin_i[i], sub_i[i], p_s[i], p_co[i], p_v[i]);
                    remain[i] = wid(i);
                    m_busy[i] = 1; m_done[i] = 0;
                    acc_cnt[i]++;
                end else begin
                    m_done[i] = 0;
                end
            end
        end
    end

    // Per-cycle compare of both instances against the model
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("w%0d_busy", wid(i)), 32'(busy_o[i]), 32'(m_busy[i]));
            chk($sformatf("w%0d_done", wid(i)), 32'(done_o[i]), 32'(m_done[i]));
            chk($sformatf("w%0d_S", wid(i)),    s_o[i],          m_s[i]);
            chk($sformatf("w%0d_Cout", wid(i)), 32'(co_o[i]),   32'(m_co[i]));
            chk($sformatf("w%0d_V", wid(i)),    32'(v_o[i]),    32'(m_v[i]));
        end
    end

    task automatic wait_done8(output int n, output int nb);
        n = 0; nb = 0;
        while (!done_o[0] && n < 30) begin
            if (busy_o[0]) nb++;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub,
                          input logic [7:0] es, input logic eco, input logic ev);
        int n, nb;
        @(negedge clk);
        st_i[0] = 1; a_i[0] = 32'(a); b_i[0] = 32'(b); cin_i[0] = cin; sub_i[0] = sub;
        @(negedge clk);
        st_i[0] = 0; a_i[0] = $urandom & 32'hFF; b_i[0] = $urandom & 32'hFF;
        wait_done8(n, nb);
        chk("latency", 32'(n), 32'd8);
        chk("busy_cycles", 32'(nb), 32'd8);
        chk("dir_S", 32'(s8), 32'(es));
        chk("dir_Cout", 32'(co8), 32'(eco));
        chk("dir_V", 32'(v8), 32'(ev));
    endtask

    task automatic pin_model(input int unsigned w, input logic [31:0] a, input logic [31:0] b,
                             input logic cin, input logic sub,
                             input logic [31:0] es, input logic eco, input logic ev);
        logic [31:0] s;
        logic co, v;
        ref_op(w, a, b, cin, sub, s, co, v);
        chk("model_S", s, es);
        chk("model_Cout", 32'(co), 32'(eco));
        chk("model_V", 32'(v), 32'(ev));
    endtask

    initial begin
        int n, nb, last_k, pulses, base0, base1, cyc;
        logic [31:0] s_hold;

        for (int i = 0; i < 2; i++) begin
            st_i[i] = 0; sub_i[i] = 0; cin_i[i] = 0; a_i[i] = 0; b_i[i] = 0; acc_cnt[i] = 0;
        end
        rst_n = 1;
        #1 rst_n = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_S", 32'(s8), 32'd0);
        rst_n = 1;

        pin_model(8, 32'h3C, 32'h21, 1, 0, 32'h5E, 0, 0);
        pin_model(8, 32'h80, 32'h01, 0, 1, 32'h7F, 1, 1);
        pin_model(2, 32'h2,  32'h1,  0, 1, 32'h1,  1, 1);
        pin_model(2, 32'h1,  32'h1,  0, 0, 32'h2,  0, 1);

        run_op(8'h3C, 8'h21, 1, 0, 8'h5E, 0, 0);
        run_op(8'hFF, 8'h01, 0, 0, 8'h00, 1, 0);
        run_op(8'h7F, 8'h01, 0, 0, 8'h80, 0, 1);
        run_op(8'h10, 8'h20, 1, 1, 8'hF0, 0, 0);
        run_op(8'h80, 8'h01, 0, 1, 8'h7F, 1, 1);

        // Asynchronous reset in the middle of an operation
        @(negedge clk);
        st_i[0] = 1; a_i[0] = 32'h55; b_i[0] = 32'h0F; sub_i[0] = 0; cin_i[0] = 0;
        @(negedge clk);
        st_i[0] = 0;
        repeat (3) @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("arst_busy", 32'(busy8), 32'd0);
        chk("arst_done", 32'(done8), 32'd0);
        chk("arst_S", 32'(s8), 32'd0);
        chk("arst_Cout", 32'(co8), 32'd0);
        chk("arst_V", 32'(v8), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        st_i[0] = 1; a_i[0] = 32'h11; b_i[0] = 32'h22; sub_i[0] = 0; cin_i[0] = 0;
        @(negedge clk);
        chk("first_start_busy", 32'(busy8), 32'd1);
        st_i[0] = 0;
        // Start during RUN with other operands must be ignored
        repeat (2) @(negedge clk);
        st_i[0] = 1; a_i[0] = 32'hFF; b_i[0] = 32'hFF; sub_i[0] = 1;
        @(negedge clk);
        st_i[0] = 0;
        wait_done8(n, nb);
        chk("ignored_start_S", 32'(s8), 32'h33);
        @(negedge clk);
        chk("ignored_start_idle", 32'(busy8), 32'd0);

        // Start held high: done every WIDTH+1 cycles, S stable between pulses
        last_k = -1; pulses = 0; s_hold = 0;
        st_i[0] = 1;
        for (int k = 0; k < 40; k++) begin
            a_i[0] = $urandom & 32'hFF; b_i[0] = $urandom & 32'hFF;
            cin_i[0] = 1'($urandom); sub_i[0] = 1'($urandom);
            @(negedge clk);
            if (done_o[0]) begin
                if (last_k >= 0) chk("hold_period", 32'(k - last_k), 32'd9);
                last_k = k; pulses++; s_hold = s_o[0];
            end else if (last_k >= 0) begin
                chk("hold_S_stable", s_o[0], s_hold);
            end
        end
        chk("hold_pulses", 32'(pulses >= 4), 32'd1);
        st_i[0] = 0;
        repeat (12) @(negedge clk);

        // Random traffic on both widths
        base0 = acc_cnt[0]; base1 = acc_cnt[1]; cyc = 0;
        while ((acc_cnt[0] - base0 < 1000 || acc_cnt[1] - base1 < 1000) && cyc < 40000) begin
            for (int i = 0; i < 2; i++) begin
                st_i[i]  = 1'($urandom);
                a_i[i]   = $urandom & wmask(i);
                b_i[i]   = $urandom & wmask(i);
                cin_i[i] = 1'($urandom);
                sub_i[i] = 1'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        chk("rand_ops_w8", 32'(acc_cnt[0] - base0 >= 1000), 32'd1);
        chk("rand_ops_w2", 32'(acc_cnt[1] - base1 >= 1000), 32'd1);
        st_i[0] = 0; st_i[1] = 0;
        repeat (12) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
